// File: rtl/mem_controller_storeless.sv
`default_nettype none
// ============================================================================
// mem_controller_storeless : fixed-priority load arbiter onto one BRAM read port
// Rev 1.0
// ============================================================================
module mem_controller_storeless #(
  parameter int NUM_LOADS = 1,
  parameter int DATA_TYPE = 32,
  parameter int ADDR_TYPE = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           memStart_valid,
  output logic                           memStart_ready,
  output logic                           memEnd_valid,
  input  logic                           memEnd_ready,
  input  logic                           ctrlEnd_valid,
  output logic                           ctrlEnd_ready,
  input  logic [NUM_LOADS*ADDR_TYPE-1:0] ldAddr,
  input  logic [NUM_LOADS-1:0]           ldAddr_valid,
  output logic [NUM_LOADS-1:0]           ldAddr_ready,
  output logic [NUM_LOADS*DATA_TYPE-1:0] ldData,
  output logic [NUM_LOADS-1:0]           ldData_valid,
  input  logic [NUM_LOADS-1:0]           ldData_ready,
  input  logic [DATA_TYPE-1:0]           loadData,
  output logic                           loadEn,
  output logic [ADDR_TYPE-1:0]           loadAddr,
  output logic                           storeEn,
  output logic [ADDR_TYPE-1:0]           storeAddr,
  output logic [DATA_TYPE-1:0]           storeData
);

  localparam int SEL_W  = (NUM_LOADS > 1) ? $clog2(NUM_LOADS) : 1;
  localparam int PEND_W = $clog2(NUM_LOADS + 1) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_END  = 2'd2
  } state_t;

  state_t               state, state_next;
  logic                 en_q;
  logic [SEL_W-1:0]     sel_q;
  logic [NUM_LOADS-1:0] valid_q;
  logic [NUM_LOADS-1:0] inflight;
  logic [NUM_LOADS-1:0] eligible;
  logic [NUM_LOADS-1:0] grant;
  logic [NUM_LOADS-1:0] data_hs;
  logic [SEL_W-1:0]     grant_idx;
  logic [DATA_TYPE-1:0] data_q [NUM_LOADS];
  logic [PEND_W-1:0]    pending;
  logic [PEND_W-1:0]    hs_count;
  logic                 found;
  logic                 all_done;

  // Fixed-priority arbitration: lowest-index eligible port wins the BRAM read.
  always_comb begin
    inflight  = '0;
    eligible  = '0;
    grant     = '0;
    grant_idx = '0;
    loadAddr  = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_LOADS; i++) begin
      inflight[i] = en_q && (sel_q == SEL_W'(i));
      eligible[i] = ldAddr_valid[i] && !inflight[i] && (!valid_q[i] || ldData_ready[i]);
      if (eligible[i] && !found) begin
        found     = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = SEL_W'(i);
        loadAddr  = ldAddr[i*ADDR_TYPE +: ADDR_TYPE];
      end
    end
  end

  assign ldAddr_ready = grant;
  assign loadEn       = found;
  assign data_hs      = valid_q & ldData_ready;
  assign ldData_valid = valid_q;

  // Several ports can drain in one cycle, so the outstanding count drops by all of them.
  always_comb begin
    hs_count = '0;
    for (int i = 0; i < NUM_LOADS; i++) begin
      hs_count = hs_count + PEND_W'(data_hs[i]);
    end
  end

  assign all_done = (pending == '0) && (ldAddr_valid == '0);

  generate
    for (genvar g = 0; g < NUM_LOADS; g++) begin : g_out
      assign ldData[g*DATA_TYPE +: DATA_TYPE] = data_q[g];
    end
  endgenerate

  // Clearing en_q on reset drops any BRAM return still on its way back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      en_q    <= 1'b0;
      sel_q   <= '0;
      valid_q <= '0;
      pending <= '0;
      for (int i = 0; i < NUM_LOADS; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      state   <= state_next;
      en_q    <= loadEn;
      sel_q   <= grant_idx;
      pending <= pending + PEND_W'(loadEn) - hs_count;
      for (int i = 0; i < NUM_LOADS; i++) begin
        if (inflight[i]) begin
          data_q[i]  <= loadData;
          valid_q[i] <= 1'b1;
        end else if (data_hs[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_next     = state;
    memStart_ready = 1'b0;
    memEnd_valid   = 1'b0;
    ctrlEnd_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        memStart_ready = 1'b1;
        if (memStart_valid) state_next = S_RUN;
      end
      S_RUN: begin
        if (ctrlEnd_valid && all_done) state_next = S_END;
      end
      S_END: begin
        memEnd_valid  = 1'b1;
        ctrlEnd_ready = memEnd_ready;
        if (memEnd_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign storeEn   = 1'b0;
  assign storeAddr = '0;
  assign storeData = '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_controller_storeless.sv
`default_nettype none
// ============================================================================
// tb_mem_controller_storeless : randomized bench with a cycle-timed reference model
// Rev 1.0
// ============================================================================
module tb_mem_controller_storeless;

  localparam int NL = 3;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  logic memStart_valid, memStart_ready;
  logic memEnd_valid, memEnd_ready;
  logic ctrlEnd_valid, ctrlEnd_ready;
  logic [NL*AW-1:0] ldAddr;
  logic [NL-1:0]    ldAddr_valid, ldAddr_ready;
  logic [NL*DW-1:0] ldData;
  logic [NL-1:0]    ldData_valid, ldData_ready;
  logic [DW-1:0]    loadData;
  logic             loadEn;
  logic [AW-1:0]    loadAddr;
  logic             storeEn;
  logic [AW-1:0]    storeAddr;
  logic [DW-1:0]    storeData;

  mem_controller_storeless #(.NUM_LOADS(NL), .DATA_TYPE(DW), .ADDR_TYPE(AW)) dut (
    .clk(clk), .rst(rst),
    .memStart_valid(memStart_valid), .memStart_ready(memStart_ready),
    .memEnd_valid(memEnd_valid), .memEnd_ready(memEnd_ready),
    .ctrlEnd_valid(ctrlEnd_valid), .ctrlEnd_ready(ctrlEnd_ready),
    .ldAddr(ldAddr), .ldAddr_valid(ldAddr_valid), .ldAddr_ready(ldAddr_ready),
    .ldData(ldData), .ldData_valid(ldData_valid), .ldData_ready(ldData_ready),
    .loadData(loadData), .loadEn(loadEn), .loadAddr(loadAddr),
    .storeEn(storeEn), .storeAddr(storeAddr), .storeData(storeData)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [256];

  // Reference: each port holds at most one load, issued at cycle iss[i];
  // its data is presented from iss+2 until accepted.
  bit            busy [NL];
  int            iss  [NL];
  logic [DW-1:0] exp_data [NL];
  int            cyc;
  int            phase;          // 0 idle, 1 running, 2 ending
  logic [NL-1:0] hs_addr, hs_data;
  bit            hs_start, hs_ctrl;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    logic [NL-1:0] eg, ov;
    logic [AW-1:0] la, exp_la;
    logic          le;
    int            first, outstanding;
    @(negedge clk);
    la = loadAddr;
    le = loadEn;
    if (rst) begin
      for (int i = 0; i < NL; i++) busy[i] = 0;
      phase    = 0;
      hs_addr  = '0;
      hs_data  = '0;
      hs_start = 0;
      hs_ctrl  = 0;
    end else begin
      first = -1;
      outstanding = 0;
      eg = '0;
      ov = '0;
      for (int i = 0; i < NL; i++) begin
        ov[i] = busy[i] && (cyc >= iss[i] + 2);
        if (busy[i]) outstanding++;
        if (first < 0 && ldAddr_valid[i] && !(busy[i] && cyc == iss[i] + 1) &&
            (!ov[i] || ldData_ready[i]))
          first = i;
      end
      exp_la = '0;
      if (first >= 0) begin
        eg[first] = 1'b1;
        exp_la = ldAddr[first*AW +: AW];
      end
      check_value("ldAddr_ready", 64'(ldAddr_ready), 64'(eg));
      check_value("ldData_valid", 64'(ldData_valid), 64'(ov));
      check_value("loadEn", 64'(loadEn), 64'(first >= 0));
      check_value("loadAddr", 64'(loadAddr), 64'(exp_la));
      for (int i = 0; i < NL; i++)
        if (ov[i]) check_value($sformatf("ldData%0d", i), 64'(ldData[i*DW +: DW]), 64'(exp_data[i]));
      check_value("store_port", 64'({storeEn, storeAddr | storeData}), 64'd0);
      check_value("memStart_ready", 64'(memStart_ready), 64'(phase == 0));
      check_value("memEnd_valid", 64'(memEnd_valid), 64'(phase == 2));
      check_value("ctrlEnd_ready", 64'(ctrlEnd_ready), 64'(phase == 2 && memEnd_ready));
      hs_addr  = ldAddr_valid & eg;
      hs_data  = ov & ldData_ready;
      hs_start = (phase == 0) && memStart_valid;
      hs_ctrl  = (phase == 2) && memEnd_ready && ctrlEnd_valid;
      case (phase)
        0: if (memStart_valid) phase = 1;
        1: if (ctrlEnd_valid && outstanding == 0 && ldAddr_valid == '0) phase = 2;
        default: if (memEnd_ready) phase = 0;
      endcase
      for (int i = 0; i < NL; i++) begin
        if (hs_data[i]) busy[i] = 0;
        if (eg[i]) begin
          busy[i] = 1;
          iss[i] = cyc;
          exp_data[i] = mem[ldAddr[i*AW +: 8]];
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
    loadData = le ? mem[la[7:0]] : $urandom;
  endtask

  // Step, then drop any address that was just accepted.
  task automatic hold_step();
    step();
    for (int i = 0; i < NL; i++) if (hs_addr[i]) ldAddr_valid[i] = 1'b0;
  endtask

  task automatic drive_random(input int pv, input int pr);
    for (int i = 0; i < NL; i++) begin
      if (!ldAddr_valid[i] || hs_addr[i]) begin
        ldAddr_valid[i] = ($urandom_range(0, 99) < pv);
        ldAddr[i*AW +: AW] = $urandom;
      end
      ldData_ready[i] = ($urandom_range(0, 99) < pr);
    end
    if (!memStart_valid || hs_start) memStart_valid = ($urandom_range(0, 9) == 0);
    if (!ctrlEnd_valid || hs_ctrl) ctrlEnd_valid = ($urandom_range(0, 7) == 0);
    memEnd_ready = $urandom_range(0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] held;
    bit seen;
    for (int a = 0; a < 256; a++) mem[a] = $urandom;
    mem[8'h10] = 32'h0000CAFE;
    for (int i = 0; i < NL; i++) begin busy[i] = 0; iss[i] = 0; exp_data[i] = '0; end
    cyc = 0; phase = 0; hs_addr = '0; hs_data = '0; hs_start = 0; hs_ctrl = 0;
    rst = 1'b1;
    memStart_valid = 0; memEnd_ready = 0; ctrlEnd_valid = 0;
    ldAddr = '0; ldAddr_valid = '0; ldData_ready = '0; loadData = '0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check_value("reset_ldData", 64'(ldData[31:0] | ldData[63:32] | ldData[95:64]), 64'd0);
    check_value("reset_memStart_ready", 64'(memStart_ready), 64'd1);
    step();

    // Single load on port 0
    ldData_ready = '1;
    ldAddr[31:0] = 32'h10;
    ldAddr_valid = 3'b001;
    hold_step();
    step();
    check_value("single_valid", 64'(ldData_valid[0]), 64'd1);
    check_value("single_data", 64'(ldData[31:0]), 64'h0000CAFE);
    step();
    check_value("single_one_cycle", 64'(ldData_valid[0]), 64'd0);

    // Priority: ports 0 and 2 together
    ldAddr[31:0] = 32'h21; ldAddr[95:64] = 32'h1_0042;
    ldAddr_valid = 3'b101;
    repeat (5) hold_step();

    // Backpressure on port 0
    ldData_ready = 3'b110;
    ldAddr[31:0] = 32'h33; ldAddr_valid = 3'b001;
    repeat (3) hold_step();
    held = ldData[31:0];
    ldAddr[31:0] = 32'h44; ldAddr_valid = 3'b001;
    for (int k = 0; k < 5; k++) begin
      hold_step();
      check_value("bp_hold", 64'(ldData[31:0]), 64'(held));
    end
    ldData_ready = 3'b111;
    repeat (4) hold_step();

    // Termination with three loads outstanding
    memStart_valid = 1; step(); memStart_valid = 0;
    ldData_ready = '0;
    ldAddr = {32'h55, 32'h66, 32'h77};
    ldAddr_valid = 3'b111;
    repeat (3) hold_step();
    ctrlEnd_valid = 1;
    repeat (5) step();
    ldData_ready = '1;
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      step();
      if (memEnd_valid) seen = 1;
    end
    check_value("term_end_seen", 64'(seen), 64'd1);
    memEnd_ready = 1;
    #1;
    check_value("term_ctrlEnd_ready", 64'(ctrlEnd_ready), 64'd1);
    step();
    ctrlEnd_valid = 0; memEnd_ready = 0;
    check_value("term_idle", 64'(memStart_ready), 64'd1);
    step();

    // Reset the cycle after a load issues
    ldAddr[31:0] = 32'h10; ldAddr_valid = 3'b001;
    hold_step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    check_value("rst_no_data", 64'(ldData_valid), 64'd0);
    check_value("rst_memStart_ready", 64'(memStart_ready), 64'd1);
    memStart_valid = 1; step(); memStart_valid = 0;
    ctrlEnd_valid = 1; step();
    check_value("rst_pending_zero", 64'(memEnd_valid), 64'd1);
    memEnd_ready = 1; step();
    ctrlEnd_valid = 0; memEnd_ready = 0;
    step();

    // Randomized traffic, including occasional resets
    for (int n = 0; n < 1500; n++) begin
      drive_random(40, 70);
      rst = ($urandom_range(0, 199) == 0);
      if (rst) ldAddr_valid = '0;
      step();
      rst = 1'b0;
    end
    ldAddr_valid = '0; ldData_ready = '1;
    memStart_valid = 0; ctrlEnd_valid = 0; memEnd_ready = 0;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
